// File: rtl/change_dispenser.sv
// Coin-return hopper driver: pays a refund greedily (quarter, dime, nickel) over a four-phase req/ack handshake.
// Build option COIN_INVENTORY_EN adds finite per-coin inventory with o_inv_low / o_inventory outputs.
module change_dispenser #(
    parameter int TIMEOUT = 255
`ifdef COIN_INVENTORY_EN
    ,
    parameter int INV_Q = 8,
    parameter int INV_D = 8,
    parameter int INV_N = 8
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [6:0]  i_amount,
    input  logic        i_eject_ack,
    output logic        o_eject_q,
    output logic        o_eject_d,
    output logic        o_eject_n,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_qnum,
    output logic [3:0]  o_dnum,
    output logic [3:0]  o_nnum,
    output logic [6:0]  o_remaining
`ifdef COIN_INVENTORY_EN
    ,
    output logic        o_inv_low,
    output logic [11:0] o_inventory
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SELECT, S_REQ, S_RELEASE, S_DONE, S_FAULT
    } state_t;

    typedef enum logic [1:0] {C_NONE, C_Q, C_D, C_N} coin_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     r_state;
    coin_t      r_coin;
    logic [6:0] r_rem;
    logic [3:0] r_qnum, r_dnum, r_nnum;
    logic       r_ej_q, r_ej_d, r_ej_n;
    logic       r_busy, r_done, r_error;
    logic [7:0] r_tmo;

    coin_t      w_coin;
    logic       w_q_ok, w_d_ok, w_n_ok;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? v : v + 4'd1;
    endfunction

    function automatic logic [6:0] coin_val(input coin_t c);
        case (c)
            C_Q:     return 7'd25;
            C_D:     return 7'd10;
            C_N:     return 7'd5;
            default: return 7'd0;
        endcase
    endfunction

`ifdef COIN_INVENTORY_EN
    logic [3:0] r_inv_q, r_inv_d, r_inv_n;

    assign w_q_ok      = (r_inv_q != 4'd0);
    assign w_d_ok      = (r_inv_d != 4'd0);
    assign w_n_ok      = (r_inv_n != 4'd0);
    assign o_inv_low   = (r_inv_q < 4'd2) || (r_inv_d < 4'd2) || (r_inv_n < 4'd2);
    assign o_inventory = {r_inv_q, r_inv_d, r_inv_n};
`else
    assign w_q_ok = 1'b1;
    assign w_d_ok = 1'b1;
    assign w_n_ok = 1'b1;
`endif

    // Largest coin that fits the remaining amount and is still in stock.
    always_comb begin
        w_coin = C_NONE;
        if (r_rem >= 7'd25 && w_q_ok)
            w_coin = C_Q;
        else if (r_rem >= 7'd10 && w_d_ok)
            w_coin = C_D;
        else if (r_rem >= 7'd5 && w_n_ok)
            w_coin = C_N;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_coin  <= C_NONE;
            r_rem   <= '0;
            r_qnum  <= '0;
            r_dnum  <= '0;
            r_nnum  <= '0;
            r_ej_q  <= 1'b0;
            r_ej_d  <= 1'b0;
            r_ej_n  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_tmo   <= '0;
`ifdef COIN_INVENTORY_EN
            r_inv_q <= 4'(INV_Q);
            r_inv_d <= 4'(INV_D);
            r_inv_n <= 4'(INV_N);
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_rem   <= i_amount;
                        r_qnum  <= '0;
                        r_dnum  <= '0;
                        r_nnum  <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                S_LOAD: r_state <= S_SELECT;
                S_SELECT: begin
                    r_coin <= w_coin;
                    r_tmo  <= '0;
                    case (w_coin)
                        C_Q: begin r_ej_q <= 1'b1; r_state <= S_REQ; end
                        C_D: begin r_ej_d <= 1'b1; r_state <= S_REQ; end
                        C_N: begin r_ej_n <= 1'b1; r_state <= S_REQ; end
                        default: begin
                            r_busy <= 1'b0;
                            // A payable residue with no usable coin is an empty hopper.
                            if (r_rem >= 7'd5) begin
                                r_error <= 1'b1;
                                r_state <= S_FAULT;
                            end else begin
                                r_done  <= 1'b1;
                                r_state <= S_DONE;
                            end
                        end
                    endcase
                end
                S_REQ: begin
                    if (i_eject_ack) begin
                        r_ej_q  <= 1'b0;
                        r_ej_d  <= 1'b0;
                        r_ej_n  <= 1'b0;
                        r_rem   <= r_rem - coin_val(r_coin);
                        r_tmo   <= '0;
                        r_state <= S_RELEASE;
                        case (r_coin)
                            C_Q: r_qnum <= sat_inc(r_qnum);
                            C_D: r_dnum <= sat_inc(r_dnum);
                            C_N: r_nnum <= sat_inc(r_nnum);
                            default: ;
                        endcase
`ifdef COIN_INVENTORY_EN
                        case (r_coin)
                            C_Q: r_inv_q <= r_inv_q - 4'd1;
                            C_D: r_inv_d <= r_inv_d - 4'd1;
                            C_N: r_inv_n <= r_inv_n - 4'd1;
                            default: ;
                        endcase
`endif
                    end else if (r_tmo == TMO_LAST) begin
                        r_ej_q  <= 1'b0;
                        r_ej_d  <= 1'b0;
                        r_ej_n  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_RELEASE: begin
                    if (!i_eject_ack) begin
                        r_state <= S_SELECT;
                    end else if (r_tmo == TMO_LAST) begin
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_state <= S_FAULT;
                    end else begin
                        r_tmo <= r_tmo + 8'd1;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                S_FAULT: r_state <= S_FAULT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_eject_q   = r_ej_q;
    assign o_eject_d   = r_ej_d;
    assign o_eject_n   = r_ej_n;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_error     = r_error;
    assign o_qnum      = r_qnum;
    assign o_dnum      = r_dnum;
    assign o_nnum      = r_nnum;
    assign o_remaining = r_rem;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomized bench for change_dispenser: greedy-payout reference model plus a behavioural hopper.
module tb_change_dispenser;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  amount = '0;
    logic        ack = 1'b0;
    logic        ej_q, ej_d, ej_n, busy, done, err;
    logic [3:0]  qnum, dnum, nnum;
    logic [6:0]  rem;
`ifdef COIN_INVENTORY_EN
    logic        inv_low;
    logic [11:0] inventory;
`endif

    int n_total = 0;
    int n_bad   = 0;

    // Hopper behaviour knobs
    bit hop_en  = 1'b1;
    int hop_dly = 1;
    int hop_rel = 1;

    // Reference model state
    int exp_seq[$];
    int exp_rem;
    int exp_cnt[3];
    bit exp_fault;
    int m_inv[3];
    int coin_value[3] = '{25, 10, 5};

    change_dispenser #(
        .TIMEOUT(16)
`ifdef COIN_INVENTORY_EN
        , .INV_Q(1), .INV_D(8), .INV_N(8)
`endif
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_amount    (amount),
        .i_eject_ack (ack),
        .o_eject_q   (ej_q),
        .o_eject_d   (ej_d),
        .o_eject_n   (ej_n),
        .o_busy      (busy),
        .o_done      (done),
        .o_error     (err),
        .o_qnum      (qnum),
        .o_dnum      (dnum),
        .o_nnum      (nnum),
        .o_remaining (rem)
`ifdef COIN_INVENTORY_EN
        ,
        .o_inv_low   (inv_low),
        .o_inventory (inventory)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_reset_inv();
`ifdef COIN_INVENTORY_EN
        m_inv = '{1, 8, 8};
`else
        m_inv = '{1000, 1000, 1000};
`endif
    endtask

    // Greedy payout from the coin rules; inventory only limits which coins are usable.
    task automatic model_refund(input int amt);
        int r;
        int c;
        exp_seq.delete();
        exp_cnt   = '{0, 0, 0};
        exp_fault = 1'b0;
        r = amt;
        while (r >= 5) begin
            if (r >= 25 && m_inv[0] > 0) c = 0;
            else if (r >= 10 && m_inv[1] > 0) c = 1;
            else if (m_inv[2] > 0) c = 2;
            else begin
                exp_fault = 1'b1;
                break;
            end
            exp_seq.push_back(c);
            r -= coin_value[c];
            if (exp_cnt[c] < 15) exp_cnt[c]++;
            m_inv[c]--;
        end
        exp_rem = r;
    endtask

    // Behavioural hopper: ack hop_dly cycles after seeing a request, release hop_rel cycles after it drops.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (hop_en && (ej_q || ej_d || ej_n)) begin
                repeat (hop_dly) @(posedge clk);
                #1 ack = 1'b1;
                for (int k = 0; k < 300; k++) begin
                    if (!(ej_q || ej_d || ej_n)) break;
                    @(posedge clk); #1;
                end
                repeat (hop_rel - 1) @(posedge clk);
                if (hop_rel > 0) @(posedge clk);
                #1 ack = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk(tag, {ej_q, ej_d, ej_n, busy, done, err, qnum, dnum, nnum, rem}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset_outputs");
`ifdef COIN_INVENTORY_EN
        chk("reset_inventory", inventory, 12'h188);
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset_inv();
    endtask

    task automatic pulse_start(input int amt);
        @(negedge clk);
        start  = 1'b1;
        amount = amt[6:0];
        @(negedge clk);
        start  = 1'b0;
        amount = 7'($urandom);
    endtask

    task automatic run_refund(input int amt);
        int obs[$];
        int cyc;
        int first_ej;
        int done_cyc;
        logic [2:0] prev;
        logic [2:0] cur;
        model_refund(amt);
        pulse_start(amt);
        cyc = 1;
        chk("busy_after_start", busy, 1);
        prev = '0;
        first_ej = -1;
        done_cyc = -1;
        while (cyc < 1500) begin
            cur = {ej_q, ej_d, ej_n};
            if (cur != 3'b000) chk("eject_onehot", $countones(cur), 1);
            if ((cur & ~prev) != 3'b000) begin
                chk("ack_low_at_req", ack, 0);
                obs.push_back(cur[2] ? 0 : (cur[1] ? 1 : 2));
                if (first_ej < 0) first_ej = cyc;
            end
            prev = cur;
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (err) break;
            start  = ($urandom_range(0, 7) == 0);
            amount = 7'($urandom);
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", (done_cyc > 0), !exp_fault);
        chk("error_flag", err, exp_fault);
        if (exp_seq.size() > 0) chk("first_eject_latency", first_ej, 3);
        else chk("done_latency", done_cyc, 3);
        chk("busy_at_done", busy, 0);
        chk("seq_len", obs.size(), exp_seq.size());
        for (int i = 0; i < obs.size() && i < exp_seq.size(); i++)
            chk("seq_coin", obs[i], exp_seq[i]);
        // A Start during the DONE cycle must be ignored.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_single_pulse", done, 0);
        @(negedge clk);
        chk("idle_after_done", {busy, done}, 0);
        chk("qnum", qnum, exp_cnt[0]);
        chk("dnum", dnum, exp_cnt[1]);
        chk("nnum", nnum, exp_cnt[2]);
        chk("remaining", rem, exp_rem);
`ifdef COIN_INVENTORY_EN
        chk("inventory", inventory, 12'(m_inv[0] * 256 + m_inv[1] * 16 + m_inv[2]));
`endif
    endtask

    initial begin
        int seen;
        int hi;
        model_reset_inv();
        repeat (2) @(negedge clk);
        check_idle_outputs("power_on_reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef COIN_INVENTORY_EN
        hop_dly = 1; hop_rel = 1;
        run_refund(50);
        chk("inv_low", inv_low, 1);
        chk("inv_q_empty", inventory[11:8], 0);
        do_reset();
`endif

        hop_dly = 1; hop_rel = 1;
        run_refund(65);
        run_refund(42);
        run_refund(0);
        run_refund(4);
        run_refund(127);

        for (int n = 0; n < 25; n++) begin
`ifdef COIN_INVENTORY_EN
            do_reset();
`endif
            hop_dly = $urandom_range(1, 5);
            hop_rel = $urandom_range(1, 4);
            run_refund($urandom_range(0, 127));
        end

        // Reset during the second quarter request of a 95-cent refund.
        hop_dly = 2; hop_rel = 1;
        pulse_start(95);
        seen = 0;
        for (int k = 0; k < 200; k++) begin
            if (qnum == 4'd1 && ej_q) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        chk("second_q_request", seen, 1);
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("reset_mid_req");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset_inv();
        repeat (12) @(negedge clk);
        hop_dly = 1; hop_rel = 1;
        run_refund(10);

        // Hopper never acknowledges: fault after TIMEOUT cycles of request.
        hop_en = 1'b0;
        pulse_start(25);
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ej_q) hi++;
            if (err) break;
        end
        chk("tmo_eject_cycles", hi, 16);
        chk("tmo_error", err, 1);
        chk("tmo_outputs_low", {ej_q, ej_d, ej_n, busy}, 0);
        pulse_start(10);
        repeat (5) @(negedge clk);
        chk("fault_ignores_start", {busy, ej_q, ej_d, ej_n}, 0);
        chk("fault_error_sticky", err, 1);
        chk("fault_rem_frozen", rem, 25);
        hop_en = 1'b1;
        do_reset();
        chk("reset_clears_error", err, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
